// File: rtl/instr_decode_queue.sv
// Buffered MIPS32 decode stage: decodes each accepted instruction word and
// queues the decoded record with its PC in a DEPTH-entry FIFO between fetch
// and issue, with a synchronous flush for redirects.

package instr_decode_queue_pkg;

  typedef enum logic [3:0] {
    OPC_INVALID = 4'd0,
    OPC_SPECIAL = 4'd1,
    OPC_J       = 4'd2,
    OPC_JAL     = 4'd3,
    OPC_BEQ     = 4'd4,
    OPC_ORI     = 4'd5,
    OPC_LUI     = 4'd6,
    OPC_LW      = 4'd7,
    OPC_SW      = 4'd8
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic        is_branch;
    logic        rs_valid;
    logic        rt_valid;
    logic        rd_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [31:0] imm16_sign_ext;
    logic [31:0] imm16_zero_ext;
    logic [25:0] jump_target;
  } instr_info_t;

endpackage

module instr_decode_queue
  import instr_decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output instr_info_t                  out_info,
  output logic [PC_W-1:0]              out_pc,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  instr_info_t     dec_info;
  logic            dec_illegal;
  logic            push;
  logic            pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  instr_info_t     info_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic            ill_mem  [DEPTH];

  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Decode the incoming word; fields that do not apply to the instruction stay zero.
  always_comb begin
    dec_info    = '0;
    dec_illegal = 1'b0;
    case (in_instr[31:26])
      6'h00: begin
        dec_info.opcode = OPC_SPECIAL;
        dec_info.funct  = in_instr[5:0];
        case (in_instr[5:0])
          6'h21, 6'h23: begin
            dec_info.rs_valid = 1'b1;
            dec_info.rt_valid = 1'b1;
            dec_info.rd_valid = 1'b1;
          end
          6'h08:   dec_info.rs_valid = 1'b1;
          6'h0c:   ;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h02: begin
        dec_info.opcode      = OPC_J;
        dec_info.jump_target = in_instr[25:0];
      end
      6'h03: begin
        dec_info.opcode      = OPC_JAL;
        dec_info.jump_target = in_instr[25:0];
      end
      6'h04: begin
        dec_info.opcode         = OPC_BEQ;
        dec_info.is_branch      = 1'b1;
        dec_info.rs_valid       = 1'b1;
        dec_info.rt_valid       = 1'b1;
        dec_info.imm16          = in_instr[15:0];
        dec_info.imm16_sign_ext = {{16{in_instr[15]}}, in_instr[15:0]};
      end
      6'h0d: begin
        dec_info.opcode         = OPC_ORI;
        dec_info.rs_valid       = 1'b1;
        dec_info.rt_valid       = 1'b1;
        dec_info.imm16          = in_instr[15:0];
        dec_info.imm16_zero_ext = {16'h0000, in_instr[15:0]};
      end
      6'h0f: begin
        dec_info.opcode   = OPC_LUI;
        dec_info.rt_valid = 1'b1;
        dec_info.imm16    = in_instr[15:0];
      end
      6'h23, 6'h2b: begin
        dec_info.opcode         = (in_instr[31:26] == 6'h23) ? OPC_LW : OPC_SW;
        dec_info.rs_valid       = 1'b1;
        dec_info.rt_valid       = 1'b1;
        dec_info.imm16          = in_instr[15:0];
        dec_info.imm16_sign_ext = {{16{in_instr[15]}}, in_instr[15:0]};
      end
      default: begin
        dec_info.opcode = OPC_INVALID;
        dec_illegal     = 1'b1;
      end
    endcase
    dec_info.rs = dec_info.rs_valid ? in_instr[25:21] : 5'd0;
    dec_info.rt = dec_info.rt_valid ? in_instr[20:16] : 5'd0;
    dec_info.rd = dec_info.rd_valid ? in_instr[15:11] : 5'd0;
  end

  // Pointer and occupancy tracking; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage is deliberately left uninitialised; only the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      info_mem[wr_ptr] <= dec_info;
      pc_mem[wr_ptr]   <= in_pc;
      ill_mem[wr_ptr]  <= dec_illegal;
    end
  end

  // Present the head entry, forcing zeros while the queue is empty.
  always_comb begin
    out_info    = '0;
    out_pc      = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_info    = info_mem[rd_ptr];
      out_pc      = pc_mem[rd_ptr];
      out_illegal = ill_mem[rd_ptr];
    end
  end

endmodule
